// File: rtl/jtbubl_romslot_if.sv
// Graphics ROM fetch bus: renderer-side rom_* request/response plus the
// SDRAM read port used to service misses.
interface jtbubl_romslot_if #(
  parameter int AW  = 18,
  parameter int SDW = 22
);
  logic           rom_cs;
  logic [AW-1:0]  rom_addr;
  logic           rom_ok;
  logic [31:0]    rom_data;
  logic           sdram_req;
  logic [SDW-1:0] sdram_addr;
  logic           sdram_ack;
  logic           data_rdy;
  logic [15:0]    sdram_din;

  // master: the renderer plus the SDRAM controller around the slot
  modport master (
    output rom_cs, rom_addr,
    input  rom_ok, rom_data,
    input  sdram_req, sdram_addr,
    output sdram_ack, data_rdy, sdram_din
  );

  modport slave (
    input  rom_cs, rom_addr,
    output rom_ok, rom_data,
    output sdram_req, sdram_addr,
    input  sdram_ack, data_rdy, sdram_din
  );
endinterface

// File: rtl/jtbubl_romslot.sv
// Graphics ROM slot: serves 32-bit renderer fetches from a 2-entry LRU cache,
// refilling misses with two 16-bit SDRAM reads.
module jtbubl_romslot #(
  parameter int             AW     = 18,
  parameter int             SDW    = 22,
  parameter logic [SDW-1:0] OFFSET = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inval,
  jtbubl_romslot_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, REQ, W0, W1, FILL} state_t;

  state_t         state, state_nx;

  logic [1:0]     valid;
  logic [AW-1:0]  cache_tag  [2];
  logic [31:0]    cache_data [2];
  logic           lru;

  logic [AW-1:0]  fetch_addr;
  logic [31:0]    fetch_buf;
  logic           fill_idx;
  logic           drop;

  logic [1:0]     hit;
  logic           hit_any;
  logic           hit_idx;

  logic           fetch_start;
  logic           cap_lo;
  logic           cap_hi;
  logic           fill_en;
  logic           req;

  logic [SDW-1:0] word_addr;
  logic [SDW-1:0] sdram_addr;
  logic           rom_ok;
  logic [31:0]    rom_data;

  assign word_addr = SDW'({bus.rom_addr, 1'b0});

  always_comb begin
    hit[0]  = bus.rom_cs & valid[0] & (cache_tag[0] == bus.rom_addr);
    hit[1]  = bus.rom_cs & valid[1] & (cache_tag[1] == bus.rom_addr);
    hit_any = |hit;
    hit_idx = ~hit[0];
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.rom_cs && !hit_any) state_nx = REQ;
      REQ:     if (bus.sdram_ack)          state_nx = W0;
      W0:      if (bus.data_rdy)           state_nx = W1;
      W1:      if (bus.data_rdy)           state_nx = FILL;
      FILL:                                state_nx = IDLE;
      default:                             state_nx = IDLE;
    endcase
  end

  // output decode; data_rdy is only looked at in W0/W1, so a pulse that
  // coincides with sdram_ack (still in REQ) or arrives in IDLE is ignored
  always_comb begin
    fetch_start = (state == IDLE) & bus.rom_cs & ~hit_any;
    cap_lo      = (state == W0) & bus.data_rdy;
    cap_hi      = (state == W1) & bus.data_rdy;
    fill_en     = (state == FILL);
    req         = (state == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdram_addr <= '0;
      fetch_addr <= '0;
      fetch_buf  <= '0;
      fill_idx   <= 1'b0;
      drop       <= 1'b0;
    end else begin
      if (fetch_start) begin
        sdram_addr <= OFFSET + word_addr;
        fetch_addr <= bus.rom_addr;
        fill_idx   <= lru;
      end
      if (cap_lo) fetch_buf[15:0]  <= bus.sdram_din;
      if (cap_hi) fetch_buf[31:16] <= bus.sdram_din;
      // an invalidate seen at any point of the fetch suppresses the fill
      if (fetch_start)  drop <= inval;
      else if (inval)   drop <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      lru      <= 1'b0;
      rom_ok   <= 1'b0;
      rom_data <= '0;
    end else begin
      if (inval) begin
        valid <= '0;
      end else begin
        if (fetch_start)        valid[lru]      <= 1'b0;
        if (fill_en && !drop)   valid[fill_idx] <= 1'b1;
      end
      rom_ok <= hit_any;
      if (hit_any) begin
        rom_data <= cache_data[hit_idx];
        lru      <= ~hit_idx;
      end
    end
  end

  // tag/data storage is qualified by valid, so it needs no reset
  always_ff @(posedge clk) begin
    if (fill_en) begin
      cache_tag[fill_idx]  <= fetch_addr;
      cache_data[fill_idx] <= fetch_buf;
    end
  end

  assign bus.sdram_req  = req;
  assign bus.sdram_addr = sdram_addr;
  assign bus.rom_ok     = rom_ok;
  assign bus.rom_data   = rom_data;

endmodule
